sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
Parametrised single-port asynchronous SRAM controller for the board's external RAM (18-bit address, 16-bit data, active-low EN/OE/WE).
- Turns a valid/ready request port from the CPU memory stage into correctly sequenced SRAM read/write strobes.
- Wait states are programmable; the tri-state data bus is owned internally.
- Returns read data / write completion on a one-cycle response pulse.

Parameters:
ADDR_W, 18, SRAM address width
DATA_W, 16, SRAM data width
STROBE_CYC, 2, cycles OE or WE is held low per access (legal range 1..15)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept; high only in IDLE and not in reset
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle pulse: read data valid / write done
rsp_rdata  out  DATA_W  read data; held until the next read completes
rsp_err  out  1  write-verify mismatch; qualified by rsp_valid; tied 0 without the macro
ram_addr  out  ADDR_W  SRAM address, registered
ram_data  inout  DATA_W  SRAM data bus
ram_en_n  out  1  chip enable, active low, registered
ram_oe_n  out  1  output enable, active low, registered
ram_we_n  out  1  write enable, active low, registered

Behaviour:
Clock and reset:
- One clock (clk). Reset is synchronous and active-high (rst).
- While rst is high at a clock edge, the FSM goes to IDLE and outputs take:
  - ram_en_n=1, ram_oe_n=1, ram_we_n=1
  - ram_addr=0, ram_data=Z
  - rsp_valid=0, rsp_err=0, rsp_rdata=0
- Reset mid-access aborts immediately. No response is issued. Strobes go inactive at that edge.

States: IDLE, RD_STROBE, WR_SETUP, WR_STROBE, WR_HOLD, DONE; plus VF_STROBE with the macro.
- Handshake: accept when req_valid && req_ready at an edge. Address, data and we are latched at that edge; later input changes are ignored.
- IDLE:
  - ram_en_n=1, ram_oe_n=1, ram_we_n=1, bus Z.
  - Accepted read goes to RD_STROBE; accepted write goes to WR_SETUP.
- RD_STROBE, STROBE_CYC cycles:
  - en_n=0, oe_n=0, we_n=1, bus Z.
  - ram_data is sampled into rsp_rdata at the edge ending the last strobe cycle.
  - Next state is DONE.
- WR_SETUP, 1 cycle: en_n=0, we_n=1, oe_n=1; bus driven with the latched data.
- WR_STROBE, STROBE_CYC cycles: we_n=0; bus driven.
- WR_HOLD, 1 cycle: we_n=1; bus still driven (data hold); next state is DONE.
- DONE, 1 cycle: rsp_valid=1, all strobes inactive, bus Z; next state is IDLE.

Timing and bus rules:
- Latency from acceptance edge to rsp_valid high:
  - read: STROBE_CYC+1 cycles
  - write: STROBE_CYC+3 cycles
- Back-to-back: the next request can be accepted at the edge ending the IDLE cycle after DONE.
- OE and WE are never low in the same cycle.
- The bus is driven only in WR_SETUP/WR_STROBE/WR_HOLD, which guarantees at least 1 turnaround cycle.
- A strobe counter counts down from STROBE_CYC-1. Its width is sized for 15.
- Address 2^ADDR_W-1 is legal; there is no wrap logic.

Optional Feature:
SRAM_WR_VERIFY_EN
- With the macro: WR_HOLD goes to VF_STROBE, which reads the same address for STROBE_CYC cycles with OE low and the bus Z.
  - The sampled word is compared with the written data.
  - rsp_err=1 in DONE on mismatch. rsp_rdata is not updated.
  - Write latency becomes 2*STROBE_CYC+3.
- Without the macro: there is no VF_STROBE state and rsp_err is constant 0.

Decomposition:
- Package sram_pkg holds the FSM state enum, STROBE_CNT_W=4 and the default widths.
- One sub-module: sram_iobuf, the tri-state buffer. Inputs: drive enable and out data. Output: in data.
- FSM and datapath stay in sram_ctrl.

Test Plan:
1. Reset: hold rst 3 cycles during a read strobe -> strobes all 1, bus Z, rsp_valid 0, req_ready 1 the cycle after rst falls.
2. Write 0xBEEF to addr 0x00012 with STROBE_CYC=2 -> WE low exactly 2 cycles with addr/data stable from SETUP through HOLD; rsp_valid at acceptance+5.
3. Read back 0x00012 from the SRAM model -> rsp_rdata=0xBEEF, rsp_valid at acceptance+3, OE low exactly 2 cycles.
4. Back-to-back write 0x1234 to 0x3FFFF then read 0x3FFFF with req_valid held -> second accept one cycle after DONE; data 0x1234; no cycle with both OE and WE low.
5. Reset asserted in WR_STROBE -> WE high next edge, no rsp_valid; a following read of that address is accepted normally.
6. With SRAM_WR_VERIFY_EN, model stuck-at-0 on bit 0, write 0x0001 -> rsp_valid with rsp_err=1 at acceptance+7; a good write of 0x5555 -> rsp_err=0.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the external asynchronous SRAM controller.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
// Contents: FSM state enum, strobe counter width, default bus widths and
// helpers that decode which strobes / bus drive a given state implies.
// The SRAM_WR_VERIFY_EN macro adds the read-after-write verify state.
package sram_pkg;

  localparam int STROBE_CNT_W = 4;   // wide enough for STROBE_CYC up to 15
  localparam int DEF_ADDR_W   = 18;
  localparam int DEF_DATA_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_STROBE,
    ST_WR_SETUP,
    ST_WR_STROBE,
    ST_WR_HOLD,
    ST_DONE
`ifdef SRAM_WR_VERIFY_EN
    , ST_VF_STROBE
`endif
  } state_t;

  // Chip is selected for every phase of an access; only IDLE/DONE release it.
  function automatic logic st_en_low(state_t s);
    return !((s == ST_IDLE) || (s == ST_DONE));
  endfunction

  function automatic logic st_oe_low(state_t s);
`ifdef SRAM_WR_VERIFY_EN
    return (s == ST_RD_STROBE) || (s == ST_VF_STROBE);
`else
    return (s == ST_RD_STROBE);
`endif
  endfunction

  // Controller owns the data bus only across setup/strobe/hold of a write.
  function automatic logic st_drives_bus(state_t s);
    return (s == ST_WR_SETUP) || (s == ST_WR_STROBE) || (s == ST_WR_HOLD);
  endfunction

endpackage

// File: rtl/sram_iobuf.sv
// Tri-state pad buffer for the SRAM data bus.
// Latency: purely combinational.
// Backpressure: none.
// Ports: i_drv_en - drive the pad with i_dout when high, else release (Z)
//        i_dout   - data to drive
//        o_din    - value currently seen on the pad
//        io_pad   - bidirectional SRAM data bus
module sram_iobuf #(
  parameter int DATA_W = 16
) (
  input  logic              i_drv_en,
  input  logic [DATA_W-1:0] i_dout,
  output logic [DATA_W-1:0] o_din,
  inout  wire  [DATA_W-1:0] io_pad
);

  assign io_pad = i_drv_en ? i_dout : {DATA_W{1'bz}};
  assign o_din  = io_pad;

endmodule

// File: rtl/sram_ctrl.sv
// Single-port asynchronous SRAM controller: valid/ready request in, strobes out, 1-cycle response pulse.
// Latency: read STROBE_CYC+1, write STROBE_CYC+3 (2*STROBE_CYC+3 with SRAM_WR_VERIFY_EN) from accept to rsp_valid.
// Backpressure: req_ready is high only in IDLE; one access in flight, no response backpressure.
// Ports: clk/rst (sync, active high); req_valid/req_ready/req_we/req_addr/req_wdata request;
//        rsp_valid/rsp_rdata/rsp_err response; ram_addr/ram_data/ram_en_n/ram_oe_n/ram_we_n SRAM pins.
// Optional macro SRAM_WR_VERIFY_EN: read back each write and flag a mismatch on rsp_err.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STROBE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              ram_en_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  localparam logic [STROBE_CNT_W-1:0] CNT_LOAD = STROBE_CNT_W'(STROBE_CYC - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [STROBE_CNT_W-1:0] r_cnt;
  logic [STROBE_CNT_W-1:0] w_cnt_nxt;
  logic [ADDR_W-1:0]       r_addr;
  logic [DATA_W-1:0]       r_wdata;
  logic [DATA_W-1:0]       r_rdata;
  logic                    r_en_n;
  logic                    r_oe_n;
  logic                    r_we_n;
  logic                    r_drv;
  logic                    r_rsp_vld;
  logic [DATA_W-1:0]       w_din;
  logic                    w_accept;
  logic                    w_last;

  assign req_ready = (r_state == ST_IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;
  assign w_last    = (r_cnt == '0);

  sram_iobuf #(.DATA_W(DATA_W)) u_iobuf (
    .i_drv_en (r_drv),
    .i_dout   (r_wdata),
    .o_din    (w_din),
    .io_pad   (ram_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = req_we ? ST_WR_SETUP : ST_RD_STROBE;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      ST_RD_STROBE: begin
        if (w_last) w_state_nxt = ST_DONE;
        else        w_cnt_nxt   = r_cnt - STROBE_CNT_W'(1);
      end
      ST_WR_SETUP: begin
        w_state_nxt = ST_WR_STROBE;
        w_cnt_nxt   = CNT_LOAD;
      end
      ST_WR_STROBE: begin
        if (w_last) w_state_nxt = ST_WR_HOLD;
        else        w_cnt_nxt   = r_cnt - STROBE_CNT_W'(1);
      end
      ST_WR_HOLD: begin
`ifdef SRAM_WR_VERIFY_EN
        w_state_nxt = ST_VF_STROBE;
        w_cnt_nxt   = CNT_LOAD;
`else
        w_state_nxt = ST_DONE;
`endif
      end
`ifdef SRAM_WR_VERIFY_EN
      ST_VF_STROBE: begin
        if (w_last) w_state_nxt = ST_DONE;
        else        w_cnt_nxt   = r_cnt - STROBE_CNT_W'(1);
      end
`endif
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Pin registers are loaded from the next state so each pin already
  // reflects a state during the whole cycle spent in that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_en_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_drv     <= 1'b0;
      r_rsp_vld <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      r_en_n    <= !st_en_low(w_state_nxt);
      r_oe_n    <= !st_oe_low(w_state_nxt);
      r_we_n    <= (w_state_nxt != ST_WR_STROBE);
      r_drv     <= st_drives_bus(w_state_nxt);
      r_rsp_vld <= (w_state_nxt == ST_DONE);
      // Capture at the edge closing the final OE-low cycle.
      if ((r_state == ST_RD_STROBE) && w_last) r_rdata <= w_din;
    end
  end

`ifdef SRAM_WR_VERIFY_EN
  logic r_rsp_err;
  // Only set on the edge entering DONE, so it is qualified by rsp_valid.
  always_ff @(posedge clk) begin
    if (rst) r_rsp_err <= 1'b0;
    else     r_rsp_err <= (r_state == ST_VF_STROBE) && w_last && (w_din != r_wdata);
  end
  assign rsp_err = r_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

  assign rsp_valid = r_rsp_vld;
  assign rsp_rdata = r_rdata;
  assign ram_addr  = r_addr;
  assign ram_en_n  = r_en_n;
  assign ram_oe_n  = r_oe_n;
  assign ram_we_n  = r_we_n;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: behavioural async SRAM model, directed requests, queue scoreboard.
// Latency: expected response cycle derived from the acceptance edge.
// Backpressure: driver holds req_valid until req_ready; monitor checks every rsp_valid pulse.
module tb_sram_ctrl;

  localparam int AW = 18;
  localparam int DW = 16;
  localparam int S  = 2;
  localparam int RD_LAT = S + 1;
`ifdef SRAM_WR_VERIFY_EN
  localparam int WR_LAT = 2 * S + 3;
  localparam int WR_OE  = S;
`else
  localparam int WR_LAT = S + 3;
  localparam int WR_OE  = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;
  logic          ram_en_n;
  logic          ram_oe_n;
  logic          ram_we_n;

  sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .STROBE_CYC(S)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_en_n(ram_en_n),
    .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: drives when selected with OE low and WE high; stores the bus
  // on every clock edge where EN and WE were low. stuck0 models bit 0 stuck at 0.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          stuck0 = 1'b0;
  logic          probe_en = 1'b0;
  logic [DW-1:0] probe_val = 16'h0F0F;
  wire           model_drv = !ram_en_n && !ram_oe_n && ram_we_n;
  wire  [DW-1:0] model_q = mem[ram_addr];
  assign ram_data = model_drv ? model_q : (probe_en ? probe_val : {DW{1'bz}});
  always @(posedge clk)
    if (!ram_en_n && !ram_we_n) mem[ram_addr] <= stuck0 ? (ram_data & 16'hFFFE) : ram_data;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
    int            acc;
  } exp_t;
  exp_t sbq[$];

  // Monitor: per-access strobe counts and stability flags, checked on each response.
  int oe_cnt = 0, we_cnt = 0, addr_bad = 0, data_bad = 0, overlap = 0;
  int last_rsp_cyc = 0;
  always @(negedge clk) begin
    if (rst) begin
      oe_cnt = 0; we_cnt = 0; addr_bad = 0; data_bad = 0;
    end else begin
      if (!ram_oe_n && !ram_we_n) overlap++;
      if (sbq.size() > 0) begin
        if (!ram_oe_n) oe_cnt++;
        if (!ram_we_n) we_cnt++;
        if (!ram_en_n && ram_addr != sbq[0].addr) addr_bad++;
        if (!ram_en_n && ram_oe_n && ram_data != sbq[0].wdata) data_bad++;
      end
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk(e.we ? "wr_latency" : "rd_latency", 32'(cyc + 1 - e.acc), 32'(e.lat));
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("oe_low_cycles", 32'(oe_cnt), e.we ? 32'(WR_OE) : 32'(S));
          chk("we_low_cycles", 32'(we_cnt), e.we ? 32'(S) : 32'd0);
          chk("addr_stable", 32'(addr_bad), 32'd0);
          chk("wdata_stable", 32'(data_bad), 32'd0);
        end
        last_rsp_cyc = cyc;
        oe_cnt = 0; we_cnt = 0; addr_bad = 0; data_bad = 0;
      end
    end
  end

  logic [DW-1:0] exp_last = '0;   // rsp_rdata expected to hold the last read word

  // For reads, d is the expected read data; for writes, the data written.
  task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic err, input bit hold, input bit push, output int acc);
    int n;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      n_vec++; n_bad++;
      $display("FAIL accept_timeout: req_ready stayed 0 for addr 0x%0h", a);
      req_valid = 1'b0; acc = -1;
      return;
    end
    acc = cyc + 1;
    if (push) begin
      e.we = we; e.addr = a; e.wdata = d; e.err = err; e.acc = acc;
      e.lat = we ? WR_LAT : RD_LAT;
      if (!we) exp_last = d;
      e.rdata = exp_last;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sbq.size() > 0 && n < 200) begin @(negedge clk); n++; end
    if (sbq.size() > 0) begin
      n_vec++; n_bad++;
      $display("FAIL rsp_timeout: %0d responses outstanding", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic chk_idle_pins(input string tag);
    chk({tag, "_en_n"}, 32'(ram_en_n), 32'd1);
    chk({tag, "_oe_n"}, 32'(ram_oe_n), 32'd1);
    chk({tag, "_we_n"}, 32'(ram_we_n), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    probe_en = 1'b1; #1;
    chk({tag, "_bus_released"}, 32'(ram_data), 32'(probe_val));
    probe_en = 1'b0;
  endtask

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } vec_t;
  vec_t tbl[3];

  initial begin
    int acc, acc2;
    tbl[0] = '{18'h00000, 16'hFFFF};
    tbl[1] = '{18'h2AAAA, 16'h0000};
    tbl[2] = '{18'h15555, 16'h8001};

    // Reset values while rst is held.
    repeat (3) @(negedge clk);
    chk_idle_pins("rst");
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;

    // Reset held 3 cycles during a read strobe aborts the read.
    do_req(1'b0, 18'h00012, 16'h0000, 1'b0, 1'b0, 1'b0, acc);
    @(negedge clk);
    chk("t1_oe_low_in_strobe", 32'(ram_oe_n), 32'd0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_pins("t1");
    rst = 1'b0;
    exp_last = '0;
    @(negedge clk);
    chk("t1_ready_after_rst", 32'(req_ready), 32'd1);

    // Write then read back.
    do_req(1'b1, 18'h00012, 16'hBEEF, 1'b0, 1'b0, 1'b1, acc);
    wait_done();
    do_req(1'b0, 18'h00012, 16'hBEEF, 1'b0, 1'b0, 1'b1, acc);
    wait_done();

    // Back-to-back at the top address with req_valid held throughout.
    do_req(1'b1, 18'h3FFFF, 16'h1234, 1'b0, 1'b1, 1'b1, acc);
    do_req(1'b0, 18'h3FFFF, 16'h1234, 1'b0, 1'b0, 1'b1, acc2);
    chk("b2b_accept_edge", 32'(acc2), 32'(last_rsp_cyc + 2));
    wait_done();

    // Data patterns: write all, then read all.
    foreach (tbl[i]) begin
      do_req(1'b1, tbl[i].a, tbl[i].d, 1'b0, 1'b0, 1'b1, acc);
      wait_done();
    end
    foreach (tbl[i]) begin
      do_req(1'b0, tbl[i].a, tbl[i].d, 1'b0, 1'b0, 1'b1, acc);
      wait_done();
    end

    // Reset during the first WE-low cycle of a write. The model commits the
    // word on that edge (WE was low before it), so the read-back sees it.
    do_req(1'b1, 18'h00100, 16'hA5A5, 1'b0, 1'b0, 1'b0, acc);
    @(negedge clk);
    @(negedge clk);
    chk("t5_we_low_before_rst", 32'(ram_we_n), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk_idle_pins("t5");
    chk("t5_rdata_cleared", 32'(rsp_rdata), 32'd0);
    rst = 1'b0;
    exp_last = '0;
    repeat (4) @(negedge clk);
    do_req(1'b0, 18'h00100, 16'hA5A5, 1'b0, 1'b0, 1'b1, acc);
    wait_done();

`ifdef SRAM_WR_VERIFY_EN
    // Verify path: stuck bit must raise rsp_err, a clean write must not.
    stuck0 = 1'b1;
    do_req(1'b1, 18'h00200, 16'h0001, 1'b1, 1'b0, 1'b1, acc);
    wait_done();
    stuck0 = 1'b0;
    do_req(1'b1, 18'h00201, 16'h5555, 1'b0, 1'b0, 1'b1, acc);
    wait_done();
`endif

    repeat (3) @(negedge clk);
    chk("oe_we_overlap_cycles", 32'(overlap), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
